// File: rtl/enemy_spawn_scheduler_pkg.sv
// enemy_pkg: shared FSM encoding and spawn id width for the spawn scheduler
package enemy_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, OVER = 2'd2} state_t;
  localparam int ID_W = 3;
endpackage

// File: rtl/enemy_spawn_scheduler_if.sv
// enemy_spawn_scheduler_if: game-core controls in, renderer/score/game-over signals out
interface enemy_spawn_scheduler_if #(parameter int NUM_ENEMIES = 4);
  import enemy_pkg::*;
  logic start;
  logic [NUM_ENEMIES-1:0] hit;
  logic [NUM_ENEMIES-1:0] enemy_active;
  logic spawn_pulse;
  logic [ID_W-1:0] spawn_id;
  logic miss_pulse;
  logic [3:0] lives_left;
  logic [7:0] score;
  logic game_over;
  modport master (
    output start, hit,
    input enemy_active, spawn_pulse, spawn_id, miss_pulse, lives_left, score, game_over
  );
  modport slave (
    input start, hit,
    output enemy_active, spawn_pulse, spawn_id, miss_pulse, lives_left, score, game_over
  );
endinterface

// File: rtl/enemy_spawn_scheduler_slot_timer.sv
// enemy_slot_timer: one enemy slot, its active flag and on-screen lifetime counter
module enemy_slot_timer #(
  parameter int LIFETIME = 150000000
) (
  input  logic clock,
  input  logic resetn,
  input  logic clr,
  input  logic load,
  input  logic hit,
  input  logic run,
  output logic active,
  output logic expire,
  output logic hit_taken
);
  localparam int W = $clog2(LIFETIME);
  localparam logic [W-1:0] LAST = W'(LIFETIME - 1);
  logic [W-1:0] cnt;
  // a hit beats a simultaneous expiry, so expire is masked by hit
  always_comb begin
    hit_taken = run && active && hit;
    expire = run && active && !hit && cnt == LAST;
  end
  // slot occupancy and age; clear wins over load, load only targets free slots
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      active <= 1'b0;
      cnt <= '0;
    end else if (clr) begin
      active <= 1'b0;
      cnt <= '0;
    end else if (load) begin
      active <= 1'b1;
      cnt <= '0;
    end else if (run && active) begin
      active <= !(hit || cnt == LAST);
      cnt <= (hit || cnt == LAST) ? '0 : cnt + W'(1);
    end
  end
endmodule

// File: rtl/enemy_spawn_scheduler.sv
// enemy_spawn_scheduler: periodic round-robin enemy spawning with hits, misses and lives
module enemy_spawn_scheduler
  import enemy_pkg::*;
#(
  parameter int NUM_ENEMIES = 4,
  parameter int SPAWN_PERIOD = 100000000,
  parameter int LIFETIME = 150000000,
  parameter int LIVES = 3
) (
  input logic clock,
  input logic resetn,
  enemy_spawn_scheduler_if.slave bus
);
  localparam int PW = $clog2(SPAWN_PERIOD);
  localparam logic [PW-1:0] P_LAST = PW'(SPAWN_PERIOD - 1);
  state_t state, state_next;
  logic [PW-1:0] pcnt;
  logic [ID_W-1:0] ptr, alloc_id;
  logic alloc_ok, init, run, over_now, spawn, clr;
  logic [NUM_ENEMIES-1:0] active, expire, hit_taken, load;
  logic [3:0] misses, hits, lives_next, j;
  logic [8:0] score_sum;
  for (genvar g = 0; g < NUM_ENEMIES; g++) begin : g_slot
    enemy_slot_timer #(.LIFETIME(LIFETIME)) u_slot (
      .clock(clock),
      .resetn(resetn),
      .clr(clr),
      .load(load[g]),
      .hit(bus.hit[g]),
      .run(run),
      .active(active[g]),
      .expire(expire[g]),
      .hit_taken(hit_taken[g])
    );
  end
  // state register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else state <= state_next;
  end
  // next state: RUN ends when the lives budget runs out, start (re)launches a game
  always_comb state_next = (state == RUN) ? (over_now ? OVER : RUN) : (bus.start ? RUN : state);
  // state decode into control strobes
  always_comb begin
    run = state == RUN;
    init = !run && bus.start;
    bus.game_over = state == OVER;
    bus.enemy_active = active;
  end
  // miss/hit popcounts, floored lives and saturating score
  always_comb begin
    misses = '0;
    hits = '0;
    for (int i = 0; i < NUM_ENEMIES; i++) begin
      misses = misses + 4'(expire[i]);
      hits = hits + 4'(hit_taken[i]);
    end
    lives_next = (bus.lives_left > misses) ? bus.lives_left - misses : '0;
    score_sum = {1'b0, bus.score} + 9'(hits);
    over_now = run && misses != '0 && lives_next == '0;
    clr = init || over_now;
  end
  // round-robin search from ptr+1 over pre-edge occupancy
  always_comb begin
    alloc_ok = 1'b0;
    alloc_id = ptr;
    j = '0;
    for (int i = 1; i <= NUM_ENEMIES; i++) begin
      j = {1'b0, ptr} + 4'(i);
      j = (j >= 4'(NUM_ENEMIES)) ? j - 4'(NUM_ENEMIES) : j;
      for (int k = 0; k < NUM_ENEMIES; k++) begin
        if (!alloc_ok && j == 4'(k) && !active[k]) begin
          alloc_ok = 1'b1;
          alloc_id = ID_W'(k);
        end
      end
    end
    spawn = run && pcnt == P_LAST && alloc_ok && !over_now;
    load = spawn ? NUM_ENEMIES'(1) << alloc_id : '0;
  end
  // period timer, allocator pointer and registered outputs
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pcnt <= '0;
      ptr <= '0;
      bus.spawn_pulse <= 1'b0;
      bus.spawn_id <= '0;
      bus.miss_pulse <= 1'b0;
      bus.lives_left <= 4'(LIVES);
      bus.score <= '0;
    end else begin
      bus.spawn_pulse <= spawn;
      bus.miss_pulse <= run && misses != '0;
      if (spawn) begin
        bus.spawn_id <= alloc_id;
        ptr <= alloc_id;
      end
      if (init) begin
        pcnt <= '0;
        ptr <= ID_W'(NUM_ENEMIES - 1);
        bus.lives_left <= 4'(LIVES);
        bus.score <= '0;
      end else if (run) begin
        pcnt <= (pcnt == P_LAST) ? '0 : pcnt + PW'(1);
        bus.lives_left <= lives_next;
        bus.score <= score_sum[8] ? 8'hff : score_sum[7:0];
      end
    end
  end
endmodule

// File: tb/tb_enemy_spawn_scheduler.sv
// tb_enemy_spawn_scheduler: scoreboarded spawns plus timed checks on two configurations
module tb_enemy_spawn_scheduler;
  typedef struct {int cyc; int id;} ev_t;
  logic clock = 1'b0;
  logic resetn = 1'b0;
  int cyc = 0;
  int base = 0;
  int total = 0;
  int passed = 0;
  ev_t qa[$];
  ev_t qb[$];
  enemy_spawn_scheduler_if #(.NUM_ENEMIES(4)) ifa ();
  enemy_spawn_scheduler_if #(.NUM_ENEMIES(4)) ifb ();
  enemy_spawn_scheduler #(.NUM_ENEMIES(4), .SPAWN_PERIOD(10), .LIFETIME(25), .LIVES(3)) u_dut (
    .clock(clock), .resetn(resetn), .bus(ifa)
  );
  enemy_spawn_scheduler #(.NUM_ENEMIES(4), .SPAWN_PERIOD(10), .LIFETIME(60), .LIVES(3)) u_dut_long (
    .clock(clock), .resetn(resetn), .bus(ifb)
  );
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  task automatic check(string tag, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask
  task automatic wait_to(int k);
    while ((cyc - base) < k) begin
      @(posedge clock);
      #1;
    end
  endtask
  task automatic push_a(int c, int id);
    ev_t e;
    e.cyc = c;
    e.id = id;
    qa.push_back(e);
  endtask
  task automatic push_b(int c, int id);
    ev_t e;
    e.cyc = c;
    e.id = id;
    qb.push_back(e);
  endtask
  always @(negedge clock) begin
    ev_t e;
    if (ifa.spawn_pulse) begin
      if (qa.size() == 0) check("a_spawn_unexpected_id", int'(ifa.spawn_id), -1);
      else begin
        e = qa.pop_front();
        check("a_spawn_cyc", cyc - base, e.cyc);
        check("a_spawn_id", int'(ifa.spawn_id), e.id);
      end
    end
    if (ifb.spawn_pulse) begin
      if (qb.size() == 0) check("b_spawn_unexpected_id", int'(ifb.spawn_id), -1);
      else begin
        e = qb.pop_front();
        check("b_spawn_cyc", cyc - base, e.cyc);
        check("b_spawn_id", int'(ifb.spawn_id), e.id);
      end
    end
  end
  initial begin
    ifa.start = 1'b0;
    ifa.hit = '0;
    ifb.start = 1'b0;
    ifb.hit = '0;
    #12;
    check("rst_active", int'(ifa.enemy_active), 0);
    check("rst_lives", int'(ifa.lives_left), 3);
    check("rst_score", int'(ifa.score), 0);
    check("rst_game_over", int'(ifa.game_over), 0);
    check("rst_spawn_id", int'(ifa.spawn_id), 0);
    #8 resetn = 1'b1;
    @(posedge clock);
    #1;
    ifa.start = 1'b1;
    ifb.start = 1'b1;
    @(posedge clock);
    #1;
    base = cyc;
    ifa.start = 1'b0;
    ifb.start = 1'b0;
    push_a(10, 0); push_a(20, 1); push_a(30, 2); push_a(40, 3);
    push_a(50, 0); push_a(60, 1); push_a(70, 2);
    push_b(10, 0); push_b(20, 1); push_b(30, 2); push_b(40, 3); push_b(80, 0);
    wait_to(9);
    check("a_no_early_spawn", int'(ifa.enemy_active), 0);
    wait_to(10);
    check("a_active_10", int'(ifa.enemy_active), 4'b0001);
    wait_to(22);
    ifa.hit = 4'b0010;
    wait_to(23);
    ifa.hit = '0;
    check("a_hit_clear", int'(ifa.enemy_active), 4'b0001);
    check("a_hit_score", int'(ifa.score), 1);
    check("a_hit_lives", int'(ifa.lives_left), 3);
    wait_to(30);
    check("a_active_30", int'(ifa.enemy_active), 4'b0101);
    check("b_active_30", int'(ifb.enemy_active), 4'b0111);
    wait_to(35);
    check("a_miss_35", int'(ifa.miss_pulse), 1);
    check("a_active_35", int'(ifa.enemy_active), 4'b0100);
    check("a_lives_35", int'(ifa.lives_left), 2);
    wait_to(36);
    check("a_miss_one_cycle", int'(ifa.miss_pulse), 0);
    wait_to(50);
    check("a_active_50", int'(ifa.enemy_active), 4'b1101);
    check("b_drop_pulse", int'(ifb.spawn_pulse), 0);
    check("b_full", int'(ifb.enemy_active), 4'b1111);
    check("b_id_held", int'(ifb.spawn_id), 3);
    wait_to(55);
    check("a_lives_55", int'(ifa.lives_left), 1);
    wait_to(64);
    ifa.hit = 4'b1000;
    wait_to(65);
    ifa.hit = '0;
    check("a_tie_score", int'(ifa.score), 2);
    check("a_tie_lives", int'(ifa.lives_left), 1);
    check("a_tie_miss", int'(ifa.miss_pulse), 0);
    check("a_tie_active", int'(ifa.enemy_active), 4'b0011);
    wait_to(70);
    check("a_active_70", int'(ifa.enemy_active), 4'b0111);
    check("b_miss_70", int'(ifb.miss_pulse), 1);
    check("b_active_70", int'(ifb.enemy_active), 4'b1110);
    check("b_lives_70", int'(ifb.lives_left), 2);
    wait_to(75);
    check("a_over_lives", int'(ifa.lives_left), 0);
    check("a_over_flag", int'(ifa.game_over), 1);
    check("a_over_active", int'(ifa.enemy_active), 0);
    check("a_over_score", int'(ifa.score), 2);
    wait_to(80);
    check("b_active_80", int'(ifb.enemy_active), 4'b1101);
    check("b_lives_80", int'(ifb.lives_left), 1);
    wait_to(90);
    check("b_over_flag", int'(ifb.game_over), 1);
    check("b_over_active", int'(ifb.enemy_active), 0);
    wait_to(100);
    check("a_over_hold", int'(ifa.game_over), 1);
    check("a_over_score_hold", int'(ifa.score), 2);
    ifa.start = 1'b1;
    @(posedge clock);
    #1;
    base = cyc;
    ifa.start = 1'b0;
    check("restart_lives", int'(ifa.lives_left), 3);
    check("restart_score", int'(ifa.score), 0);
    check("restart_game_over", int'(ifa.game_over), 0);
    push_a(10, 0); push_a(20, 1);
    wait_to(27);
    check("pre_rst_active", int'(ifa.enemy_active), 4'b0011);
    #2 resetn = 1'b0;
    #1;
    check("arst_active", int'(ifa.enemy_active), 0);
    check("arst_spawn_id", int'(ifa.spawn_id), 0);
    check("arst_lives", int'(ifa.lives_left), 3);
    check("arst_score", int'(ifa.score), 0);
    check("arst_pulses", int'({ifa.spawn_pulse, ifa.miss_pulse}), 0);
    check("arst_b_game_over", int'(ifb.game_over), 0);
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    repeat (15) @(posedge clock);
    #1;
    check("idle_active", int'(ifa.enemy_active), 0);
    check("idle_game_over", int'(ifa.game_over), 0);
    check("a_sb_drain", qa.size(), 0);
    check("b_sb_drain", qb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
